// File: rtl/modacc.sv
// Streaming modular accumulator: sums a burst of residues modulo
// q = qH * 2^(LOGQ-LOGQH) + 1 and returns the final residue over valid/ready.
module modacc #(
  parameter int LOGQ  = 64,
  parameter int LOGQH = 47,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LOGQH-1:0] qH,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [LOGQ-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [LOGQ-1:0]  out_data,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Expand the modulus high part into the full-width modulus.
  function automatic logic [LOGQ-1:0] build_q(input logic [LOGQH-1:0] qh);
    logic [LOGQ-1:0] q_v;
    if (LOGQ > LOGQH) begin
      q_v = (LOGQ'(qh) << (LOGQ - LOGQH)) | {{(LOGQ-1){1'b0}}, 1'b1};
    end else begin
      q_v = LOGQ'(qh);
    end
    return q_v;
  endfunction

  state_t           state_r;
  logic [LOGQ-1:0]  acc_r;
  logic [LOGQ-1:0]  q_r;
  logic [CNT_W-1:0] cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic [LOGQ:0]    sum_s;
  logic [LOGQ+1:0]  diff_s;
  logic [LOGQ-1:0]  next_acc_s;
  logic             unused_s;

  // One modular add: keep the raw sum if subtracting q goes negative.
  always_comb begin
    sum_s  = {1'b0, acc_r} + {1'b0, in_data};
    diff_s = {1'b0, sum_s} - {2'b00, q_r};
    if (diff_s[LOGQ+1]) begin
      next_acc_s = sum_s[LOGQ-1:0];
    end else begin
      next_acc_s = diff_s[LOGQ-1:0];
    end
  end

  // A non-negative difference is always below q, so its top magnitude bit is zero.
  assign unused_s = diff_s[LOGQ];

  // Burst control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      acc_r       <= '0;
      q_r         <= '0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            acc_r  <= '0;
            q_r    <= build_q(qH);
            cnt_r  <= len;
            busy_r <= 1'b1;
            if (len != '0) begin
              state_r    <= ST_ACC;
              in_ready_r <= 1'b1;
            end else begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
            end
          end
        end
        ST_ACC: begin
          if (in_valid && in_ready_r) begin
            acc_r <= next_acc_s;
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
              state_r     <= ST_DONE;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_valid_r && out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = acc_r;
  assign busy      = busy_r;

endmodule
